// File: rtl/ex_mul_div_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit and the forwarding unit.
// Also holds the mul/div FSM state type.
package ex_mul_div_unit_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

  // MULT and DIV are the signed flavours (op bit 0 clear).
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/ex_mul_div_unit_fwd_mux.sv
// 3:1 operand select driven by a forwarding code; the unused code 11 falls
// back to the register-file value.
module operand_fwd_mux
  import ex_mul_div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        sel_i,
  input  logic [DATA_W-1:0] rf_i,
  input  logic [DATA_W-1:0] exmem_i,
  input  logic [DATA_W-1:0] memwb_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = rf_i;
    case (sel_i)
      FWD_EXMEM: data_o = exmem_i;
      FWD_MEMWB: data_o = memwb_i;
      default:   data_o = rf_i;
    endcase
  end

endmodule

// File: rtl/ex_mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers for the EX stage.
// One shift-add or restoring-divide step per cycle; stalls the front end while busy.
module ex_mul_div_unit
  import ex_mul_div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              op_valid_i,
  input  logic [1:0]        op_i,
  input  logic              flush_i,
  input  logic [1:0]        forwardA_i,
  input  logic [1:0]        forwardB_i,
  input  logic [DATA_W-1:0] id_ex_rs_data_i,
  input  logic [DATA_W-1:0] id_ex_rt_data_i,
  input  logic [DATA_W-1:0] ex_mem_data_i,
  input  logic [DATA_W-1:0] mem_wb_data_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              is_div_q, is_div_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;
  logic              div_zero_q, div_zero_d;

  logic [DATA_W-1:0] op_a, op_b, a_abs, b_abs;
  logic              sign_a, sign_b, issue;

  logic [DATA_W:0]     mul_sum;
  logic [DATA_W-1:0]   mul_hi_nx, mul_lo_nx;
  logic [2*DATA_W-1:0] mul_prod, mul_fin;
  logic [DATA_W:0]     div_shift;
  logic                div_ok;
  logic [DATA_W-1:0]   div_diff, div_rem_nx, div_quo_nx, div_q_fin, div_r_fin;

  operand_fwd_mux #(.DATA_W(DATA_W)) u_fwd_a (
    .sel_i   (forwardA_i),
    .rf_i    (id_ex_rs_data_i),
    .exmem_i (ex_mem_data_i),
    .memwb_i (mem_wb_data_i),
    .data_o  (op_a)
  );

  operand_fwd_mux #(.DATA_W(DATA_W)) u_fwd_b (
    .sel_i   (forwardB_i),
    .rf_i    (id_ex_rt_data_i),
    .exmem_i (ex_mem_data_i),
    .memwb_i (mem_wb_data_i),
    .data_o  (op_b)
  );

  always_comb begin
    sign_a = op_is_signed(op_i) & op_a[DATA_W-1];
    sign_b = op_is_signed(op_i) & op_b[DATA_W-1];
    a_abs  = sign_a ? -op_a : op_a;
    b_abs  = sign_b ? -op_b : op_b;
    issue  = (state_q == ST_IDLE) & op_valid_i & ~flush_i;
  end

  // Multiply: {acc, work} shifts right, multiplicand added on work[0].
  // Divide: dividend bits leave the top of work, quotient bits enter at the bottom.
  always_comb begin
    mul_sum    = {1'b0, acc_q} + (work_q[0] ? {1'b0, opb_q} : '0);
    mul_hi_nx  = mul_sum[DATA_W:1];
    mul_lo_nx  = {mul_sum[0], work_q[DATA_W-1:1]};
    mul_prod   = {mul_hi_nx, mul_lo_nx};
    mul_fin    = neg_lo_q ? -mul_prod : mul_prod;

    div_shift  = {acc_q, work_q[DATA_W-1]};
    div_ok     = (div_shift >= {1'b0, opb_q});
    div_diff   = div_shift[DATA_W-1:0] - opb_q;
    div_rem_nx = div_ok ? div_diff : div_shift[DATA_W-1:0];
    div_quo_nx = {work_q[DATA_W-2:0], div_ok};
    // A zero divisor leaves |A| in the remainder, so the sign fix restores A itself.
    div_q_fin  = div_zero_q ? '1 : (neg_lo_q ? -div_quo_nx : div_quo_nx);
    div_r_fin  = neg_hi_q ? -div_rem_nx : div_rem_nx;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    work_d     = work_q;
    opb_d      = opb_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    div_zero_d = div_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          is_div_d   = op_i[1];
          acc_d      = '0;
          cnt_d      = CNT_W'(DATA_W);
          neg_lo_d   = sign_a ^ sign_b;
          neg_hi_d   = sign_a;
          div_zero_d = (op_b == '0);
          work_d     = op_i[1] ? a_abs : b_abs;
          opb_d      = op_i[1] ? b_abs : a_abs;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          acc_d  = is_div_q ? div_rem_nx : mul_hi_nx;
          work_d = is_div_q ? div_quo_nx : mul_lo_nx;
          if (cnt_q == CNT_W'(1)) begin
            hi_d    = is_div_q ? div_r_fin : mul_fin[2*DATA_W-1:DATA_W];
            lo_d    = is_div_q ? div_q_fin : mul_fin[DATA_W-1:0];
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      work_q     <= '0;
      opb_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      work_q     <= work_d;
      opb_q      <= opb_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign stall_o     = rst_i & (issue | (state_q == ST_BUSY));
  assign done_o      = (state_q == ST_DONE);
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ex_mul_div_unit.sv
// Bench for ex_mul_div_unit: transaction-level HI/LO model with per-cycle
// compare, directed literal cases and randomized mul/div/flush traffic.
module tb_ex_mul_div_unit;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         op_valid_i;
  logic [1:0]   op_i;
  logic         flush_i;
  logic [1:0]   forwardA_i, forwardB_i;
  logic [W-1:0] id_ex_rs_data_i, id_ex_rt_data_i, ex_mem_data_i, mem_wb_data_i;
  logic         stall_o, done_o;
  logic [W-1:0] hi_o, lo_o;
  logic [1:0]   dbg_state_o;

  int total = 0;
  int bad   = 0;

  ex_mul_div_unit #(.DATA_W(W)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .op_valid_i      (op_valid_i),
    .op_i            (op_i),
    .flush_i         (flush_i),
    .forwardA_i      (forwardA_i),
    .forwardB_i      (forwardB_i),
    .id_ex_rs_data_i (id_ex_rs_data_i),
    .id_ex_rt_data_i (id_ex_rt_data_i),
    .ex_mem_data_i   (ex_mem_data_i),
    .mem_wb_data_i   (mem_wb_data_i),
    .stall_o         (stall_o),
    .done_o          (done_o),
    .hi_o            (hi_o),
    .lo_o            (lo_o),
    .dbg_state_o     (dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd_sel(input logic [1:0] s, input logic [31:0] rf,
                                          input logic [31:0] exm, input logic [31:0] mwb);
    if (s == 2'b01) return exm;
    if (s == 2'b10) return mwb;
    return rf;
  endfunction

  // Returns {HI, LO}.
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sp;
    int sa, sb, q, r;
    case (op)
      2'b00: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      2'b01: return {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b11) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a; sb = b;
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
    endcase
  endfunction

  int          m_left;
  logic        m_done;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;

  // Instruction-level model: W busy cycles after issue, then one done cycle.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_pend <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      if (flush_i) begin
        m_left <= 0;
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
          m_done <= 1'b1;
        end
      end
    end else if (op_valid_i && !flush_i) begin
      m_pend <= ref_op(op_i,
                       fwd_sel(forwardA_i, id_ex_rs_data_i, ex_mem_data_i, mem_wb_data_i),
                       fwd_sel(forwardB_i, id_ex_rt_data_i, ex_mem_data_i, mem_wb_data_i));
      m_left <= W;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_i) begin
    logic exp_stall;
    exp_stall = rst_i && ((m_left == 0 && !m_done && op_valid_i && !flush_i) || m_left > 0);
    check("stall", {31'b0, stall_o}, {31'b0, exp_stall});
    check("done",  {31'b0, done_o},  {31'b0, m_done});
    check("hi",    hi_o, m_hi);
    check("lo",    lo_o, m_lo);
  end

  // ---------------- driver ----------------
  // flush_at = k (1..W) flushes in the k-th busy cycle; W+1 raises flush in the done cycle.
  task automatic run_op(input logic [1:0] op, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] exm, input logic [31:0] mwb, input int flush_at,
                        output int stall_cycles, output int done_at, output logic saw_done,
                        output logic [31:0] hi, output logic [31:0] lo);
    @(posedge clk_i); #1;
    op_valid_i = 1'b1; op_i = op; flush_i = 1'b0;
    forwardA_i = fa; forwardB_i = fb;
    id_ex_rs_data_i = rs; id_ex_rt_data_i = rt;
    ex_mem_data_i = exm; mem_wb_data_i = mwb;
    stall_cycles = 0; done_at = -1; saw_done = 1'b0; hi = '0; lo = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_i);
      if (stall_o) stall_cycles++;
      if (done_o && !saw_done) begin
        saw_done = 1'b1; done_at = c; hi = hi_o; lo = lo_o;
      end
      @(posedge clk_i); #1;
      if (saw_done || (flush_at > 0 && c == flush_at)) begin
        op_valid_i = 1'b0; flush_i = 1'b0;
        break;
      end
      if (c == 0) begin
        ex_mem_data_i = $urandom;
        mem_wb_data_i = $urandom;
      end
      if (flush_at > 0 && c + 1 == flush_at) begin
        flush_i = 1'b1;
        if (flush_at <= W) op_valid_i = 1'b0;
      end
    end
    op_valid_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic directed(input string name, input logic [1:0] op, input logic [1:0] fa,
                          input logic [1:0] fb, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] exm, input logic [31:0] mwb,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int sc, da;
    logic sd;
    logic [31:0] h, l;
    run_op(op, fa, fb, rs, rt, exm, mwb, 0, sc, da, sd, h, l);
    check({name, "_done_seen"}, {31'b0, sd}, 32'd1);
    check({name, "_stall_cycles"}, sc, 32'd33);
    check({name, "_done_at"}, da, 32'd33);
    check({name, "_hi"}, h, exp_hi);
    check({name, "_lo"}, l, exp_lo);
  endtask

  initial begin
    int sc, da;
    logic sd;
    logic [31:0] h, l, rs, rt;
    int fl;

    rst_i = 1'b0; op_valid_i = 1'b0; op_i = 2'b00; flush_i = 1'b0;
    forwardA_i = 2'b00; forwardB_i = 2'b00;
    id_ex_rs_data_i = '0; id_ex_rt_data_i = '0; ex_mem_data_i = '0; mem_wb_data_i = '0;
    #1;
    op_valid_i = 1'b1;
    #1;
    check("reset_stall", {31'b0, stall_o}, 32'd0);
    check("reset_hi", hi_o, 32'h0);
    check("reset_lo", lo_o, 32'h0);
    op_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;

    directed("multu_max", 2'b01, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0,
             32'hFFFF_FFFE, 32'h0000_0001);
    directed("mult_fwd_exmem", 2'b00, 2'b01, 2'b00, 32'h1234_0000, 32'd7, 32'hFFFF_FFFD,
             32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    directed("div_fwd_memwb", 2'b10, 2'b00, 2'b10, 32'hFFFF_FFF9, 32'h55, 32'h0, 32'd2,
             32'hFFFF_FFFF, 32'hFFFF_FFFD);
    directed("div_min_neg1", 2'b10, 2'b00, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0,
             32'h0, 32'h8000_0000);
    directed("divu_by_zero", 2'b11, 2'b00, 2'b00, 32'h1234_5678, 32'h0, 32'h0, 32'h0,
             32'h1234_5678, 32'hFFFF_FFFF);
    directed("div_neg_by_zero", 2'b10, 2'b11, 2'b11, 32'hFFFF_FF00, 32'h0, 32'h9, 32'h9,
             32'hFFFF_FF00, 32'hFFFF_FFFF);
    directed("divu_seed", 2'b11, 2'b00, 2'b00, 32'h0000_2211, 32'h0000_0100, 32'h0, 32'h0,
             32'h11, 32'h22);

    // flush in the 10th busy cycle: aborted, HI/LO keep 0x11/0x22
    run_op(2'b01, 2'b00, 2'b00, 32'd1000, 32'd1000, 32'h0, 32'h0, 10, sc, da, sd, h, l);
    @(negedge clk_i);
    check("flush_no_done", {31'b0, sd}, 32'd0);
    check("flush_stall", {31'b0, stall_o}, 32'd0);
    check("flush_hi", hi_o, 32'h11);
    check("flush_lo", lo_o, 32'h22);

    // flush in IDLE wins over issue
    @(posedge clk_i); #1;
    op_valid_i = 1'b1; flush_i = 1'b1; op_i = 2'b01;
    #1 check("idle_flush_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk_i); #1;
    op_valid_i = 1'b0; flush_i = 1'b0;
    #1 check("idle_flush_no_issue", {31'b0, stall_o}, 32'd0);

    // reset in the middle of a multiply
    @(posedge clk_i); #1;
    op_valid_i = 1'b1; op_i = 2'b01; forwardA_i = 2'b00; forwardB_i = 2'b00;
    id_ex_rs_data_i = 32'hDEAD_BEEF; id_ex_rt_data_i = 32'h1234;
    repeat (5) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    check("rst_mid_hi", hi_o, 32'h0);
    check("rst_mid_lo", lo_o, 32'h0);
    check("rst_mid_stall", {31'b0, stall_o}, 32'd0);
    check("rst_mid_done", {31'b0, done_o}, 32'd0);
    op_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    directed("multu_after_rst", 2'b01, 2'b00, 2'b00, 32'd3, 32'd5, 32'h0, 32'h0,
             32'h0, 32'd15);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      rs = $urandom; rt = $urandom;
      case ($urandom_range(0, 7))
        0: rt = 32'h0;
        1: begin rs = 32'h8000_0000; rt = 32'hFFFF_FFFF; end
        2: begin rs = $urandom_range(0, 50); rt = $urandom_range(0, 9); end
        3: rs = -$urandom_range(1, 1000);
        default: ;
      endcase
      fl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W + 1) : 0;
      run_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             rs, rt, $urandom, $urandom, fl, sc, da, sd, h, l);
      check("rand_done_seen", {31'b0, sd}, {31'b0, (fl == 0 || fl > W)});
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
    end

    repeat (3) @(posedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_mul_div_unit.md
Name: ex_mul_div_unit

Overview:
- Multi-cycle MULT/MULTU/DIV/DIVU unit in the EX stage of the 5-stage pipeline, directly downstream of the forwarding unit.
- Selects each operand from the register file, EX/MEM or MEM/WB value using the forwardA/forwardB select codes.
- Runs an iterative shift-add multiply or restoring divide, holds the HI/LO registers, and stalls the pipeline while busy.

Parameters:
DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
op_valid_i  in  1  ID/EX holds a mul/div instruction
op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
flush_i  in  1  squash the in-flight operation
forwardA_i  in  2  rs select: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 treated as 00
forwardB_i  in  2  rt select, same encoding
id_ex_rs_data_i  in  DATA_W  rs from ID/EX register
id_ex_rt_data_i  in  DATA_W  rt from ID/EX register
ex_mem_data_i  in  DATA_W  EX/MEM ALU result
mem_wb_data_i  in  DATA_W  MEM/WB write-back data
stall_o  out  1  freeze PC, IF/ID and ID/EX
done_o  out  1  one-cycle completion pulse
hi_o  out  DATA_W  HI register (product high / remainder)
lo_o  out  DATA_W  LO register (product low / quotient)

Behaviour:
- Reset (rst_i=0, async): state IDLE, hi_o=0, lo_o=0, done_o=0, all internal registers 0. stall_o is forced 0 while in reset.
- Operand A = mux(forwardA_i); operand B = mux(forwardB_i). Both are sampled only in the issue cycle.
- FSM states: IDLE, BUSY, DONE.
- IDLE, op_valid_i=1, flush_i=0 (cycle T):
  - Capture operands.
  - Signed ops: take absolute values and record the result signs. Quotient sign = signA XOR signB; remainder sign = signA; product sign = XOR.
  - Load counter with DATA_W; go to BUSY.
- BUSY:
  - One iteration per cycle; counter decrements.
  - On the last iteration (counter==1): apply sign correction, write HI/LO at that edge, go to DONE.
- DONE (cycle T+DATA_W+1):
  - done_o=1, stall_o=0. New HI/LO are visible.
  - Unconditionally go to IDLE. op_valid_i is ignored in this cycle, so the stalled instruction does not retrigger.
- stall_o is combinational: (IDLE & op_valid_i & ~flush_i) | BUSY.
  - It is high for exactly DATA_W+1 cycles (T..T+DATA_W).
- Multiply: 2*DATA_W-bit product. HI = upper half, LO = lower half. Signed result is the two's-complement negation of the full 2*DATA_W product.
- Divide: LO = quotient, HI = remainder.
  - Divide by zero (any sign): HI = operand A, LO = all ones. Full latency still applies.
  - Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No exception.
- Flush:
  - flush_i in BUSY: abort to IDLE next edge. HI/LO unchanged, done_o never pulses, stall_o low from the next cycle.
  - flush_i in IDLE has priority over issue: no capture, stall_o=0.
  - flush_i in DONE: no effect; HI/LO are already committed.
- Reset mid-BUSY aborts immediately; all outputs take their reset values.
- HI/LO change only on completion or reset.

Decomposition:
- Shared package holds:
  - op_i encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
  - Forward-select encodings (FWD_RF=00, FWD_EXMEM=01, FWD_MEMWB=10); the forwarding unit uses the same constants.
  - FSM state enum.
- One sub-module: operand_fwd_mux (3:1 select by 2-bit code, 11 falls back to regfile), instantiated twice.
- Multiply/divide datapath and FSM stay in this module.

Test Plan:
- MULTU, fwd 00/00, rs=0xFFFFFFFF, rt=0xFFFFFFFF -> stall_o high 33 cycles, done_o at T+33, HI=0xFFFFFFFE, LO=0x00000001.
- MULT, forwardA=01, ex_mem=0xFFFFFFFD (-3), rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21). Changing ex_mem after T does not alter the result.
- DIV, forwardB=10, rs=0xFFFFFFF9 (-7), mem_wb=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Also DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x12345678/0 -> HI=0x12345678, LO=0xFFFFFFFF after full latency; done_o pulses once.
- HI/LO=0x11/0x22, issue MULTU, flush_i at 10th BUSY cycle -> IDLE next cycle, stall_o=0, no done_o, HI/LO stay 0x11/0x22.
- rst_i low mid-BUSY -> hi_o=lo_o=0, stall_o=0, done_o=0 immediately. After release, a new MULTU 3*5 gives LO=15, HI=0.
